// File: rtl/ros2_eth_tx_wide_adapter.sv
// IPv4 TX adapter: parses a byte-wide header stream into header fields for the IP engine and
// repacks the payload into DATA_BYTES-wide AXI-Stream words with tkeep.
module ros2_eth_tx_wide_adapter #(
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_enable,
  input  logic [7:0]              i_din_data,
  input  logic                    i_din_empty_n,
  output logic                    o_din_rd_en,
  output logic                    o_tx_hdr_valid,
  input  logic                    i_tx_hdr_ready,
  output logic [5:0]              o_tx_ip_dscp,
  output logic [1:0]              o_tx_ip_ecn,
  output logic [15:0]             o_tx_ip_length,
  output logic [7:0]              o_tx_ip_ttl,
  output logic [7:0]              o_tx_ip_protocol,
  output logic [31:0]             o_tx_ip_source_ip,
  output logic [31:0]             o_tx_ip_dest_ip,
  output logic [3:0]              o_tx_ip_ihl,
  output logic                    o_tx_payload_tvalid,
  input  logic                    i_tx_payload_tready,
  output logic [8*DATA_BYTES-1:0] o_tx_payload_tdata,
  output logic [DATA_BYTES-1:0]   o_tx_payload_tkeep,
  output logic [DATA_BYTES-1:0]   o_tx_payload_tstrb,
  output logic                    o_tx_payload_tlast,
  output logic                    o_hdr_error
);

  localparam int unsigned LaneW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int unsigned DataW = 8 * DATA_BYTES;

  typedef enum logic [1:0] {StReadHdr, StSkipOpt, StTxHdr, StPayload} state_e;

  typedef struct packed {
    logic [3:0]  version;
    logic [3:0]  ihl;
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [15:0] length;
    logic [7:0]  ttl;
    logic [7:0]  protocol;
    logic [31:0] source_ip;
    logic [31:0] dest_ip;
  } hdr_t;

  state_e                state_q, state_d;
  hdr_t                  hdr_q, hdr_d;
  logic [15:0]           offset_q, offset_d;
  logic [15:0]           remaining_q, remaining_d;
  logic [LaneW-1:0]      lane_q, lane_d;
  logic [DataW-1:0]      pack_q, pack_d;
  logic [DataW-1:0]      out_data_q, out_data_d;
  logic [DATA_BYTES-1:0] out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  hdr_error_q, hdr_error_d;

  logic [15:0]           hdr_bytes;
  logic [15:0]           payload_len;
  logic                  hdr_ok;
  logic                  word_done;
  logic [DATA_BYTES-1:0] keep_fill;

  assign hdr_bytes   = {10'd0, hdr_q.ihl, 2'b00};
  assign payload_len = hdr_q.length - hdr_bytes;
  assign hdr_ok      = (hdr_q.version == 4'd4) && (hdr_q.ihl >= 4'd5) &&
                       (hdr_q.length >= hdr_bytes);
  assign word_done   = (lane_q == LaneW'(DATA_BYTES - 1)) || (remaining_q == 16'd1);

  always_comb begin
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      keep_fill[i] = (i <= 32'(lane_q));
    end
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    lane_d      = lane_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;
    hdr_error_d = 1'b0;
    o_din_rd_en = 1'b0;

    if (!i_enable) begin
      // Abort: header registers keep their last values, everything in flight is dropped.
      state_d     = StReadHdr;
      offset_d    = '0;
      out_valid_d = 1'b0;
      pack_d      = '0;
      lane_d      = '0;
    end else begin
      unique case (state_q)
        StReadHdr: begin
          o_din_rd_en = i_din_empty_n;
          if (i_din_empty_n) begin
            case (offset_q)
              16'd0:   {hdr_d.version, hdr_d.ihl} = i_din_data;
              16'd1:   {hdr_d.dscp, hdr_d.ecn} = i_din_data;
              16'd2:   hdr_d.length[15:8] = i_din_data;
              16'd3:   hdr_d.length[7:0] = i_din_data;
              16'd8:   hdr_d.ttl = i_din_data;
              16'd9:   hdr_d.protocol = i_din_data;
              16'd12:  hdr_d.source_ip[31:24] = i_din_data;
              16'd13:  hdr_d.source_ip[23:16] = i_din_data;
              16'd14:  hdr_d.source_ip[15:8] = i_din_data;
              16'd15:  hdr_d.source_ip[7:0] = i_din_data;
              16'd16:  hdr_d.dest_ip[31:24] = i_din_data;
              16'd17:  hdr_d.dest_ip[23:16] = i_din_data;
              16'd18:  hdr_d.dest_ip[15:8] = i_din_data;
              16'd19:  hdr_d.dest_ip[7:0] = i_din_data;
              default: ;
            endcase
            offset_d = offset_q + 16'd1;
            // Validation needs only version, ihl and length, all captured well before byte 19.
            if (offset_q == 16'd19) begin
              if (!hdr_ok) begin
                hdr_error_d = 1'b1;
                offset_d    = '0;
              end else if (hdr_q.ihl > 4'd5) begin
                state_d = StSkipOpt;
              end else begin
                state_d = StTxHdr;
              end
            end
          end
        end
        StSkipOpt: begin
          o_din_rd_en = i_din_empty_n;
          if (i_din_empty_n) begin
            offset_d = offset_q + 16'd1;
            if (offset_q == hdr_bytes - 16'd1) state_d = StTxHdr;
          end
        end
        StTxHdr: begin
          offset_d = '0;
          if (i_tx_hdr_ready) begin
            if (payload_len == 16'd0) begin
              state_d = StReadHdr;
            end else begin
              state_d     = StPayload;
              remaining_d = payload_len;
              lane_d      = '0;
            end
          end
        end
        StPayload: begin
          if (out_valid_q && i_tx_payload_tready) begin
            out_valid_d = 1'b0;
            if (out_last_q) state_d = StReadHdr;
          end
          o_din_rd_en = i_din_empty_n && (remaining_q != 16'd0) &&
                        (!out_valid_q || i_tx_payload_tready);
          if (o_din_rd_en) begin
            pack_d[8*int'(lane_q) +: 8] = i_din_data;
            remaining_d = remaining_q - 16'd1;
            if (word_done) begin
              out_valid_d = 1'b1;
              out_data_d  = pack_d;
              out_keep_d  = keep_fill;
              out_last_d  = (remaining_q == 16'd1);
              pack_d      = '0;
              lane_d      = '0;
            end else begin
              lane_d = lane_q + LaneW'(1);
            end
          end
        end
        default: state_d = StReadHdr;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= StReadHdr;
      hdr_q       <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      lane_q      <= '0;
      pack_q      <= '0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      hdr_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
      lane_q      <= lane_d;
      pack_q      <= pack_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
      hdr_error_q <= hdr_error_d;
    end
  end

  assign o_tx_hdr_valid      = (state_q == StTxHdr);
  assign o_tx_ip_dscp        = hdr_q.dscp;
  assign o_tx_ip_ecn         = hdr_q.ecn;
  assign o_tx_ip_length      = hdr_q.length;
  assign o_tx_ip_ttl         = hdr_q.ttl;
  assign o_tx_ip_protocol    = hdr_q.protocol;
  assign o_tx_ip_source_ip   = hdr_q.source_ip;
  assign o_tx_ip_dest_ip     = hdr_q.dest_ip;
  assign o_tx_ip_ihl         = hdr_q.ihl;
  assign o_tx_payload_tvalid = out_valid_q;
  assign o_tx_payload_tdata  = out_data_q;
  assign o_tx_payload_tkeep  = out_keep_q;
  assign o_tx_payload_tstrb  = out_keep_q;
  assign o_tx_payload_tlast  = out_last_q;
  assign o_hdr_error         = hdr_error_q;

endmodule

// File: tb/tb_ros2_eth_tx_wide_adapter.sv
// Bench for the wide TX adapter: DATA_BYTES 4/1/8 instances share one FIFO model and only the
// selected instance is enabled; a packet-level model predicts headers, words and errors.
module tb_ros2_eth_tx_wide_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en;
  logic [1:0] sel;
  logic [7:0] din;
  logic       empty_n;
  logic       hdr_ready;
  logic       tready;
  bit         rnd;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } word_t;

  logic         rd_v [3];
  logic         hv_v [3];
  logic [107:0] hf_v [3];
  logic         tv_v [3];
  logic [63:0]  td_v [3];
  logic [7:0]   tk_v [3];
  logic [7:0]   ts_v [3];
  logic         tl_v [3];
  logic         er_v [3];

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int unsigned DB = (k == 0) ? 4 : ((k == 1) ? 1 : 8);
    logic [8*DB-1:0] td;
    logic [DB-1:0]   tk;
    logic [DB-1:0]   ts;
    logic [5:0]      dscp;
    logic [1:0]      ecn;
    logic [15:0]     length;
    logic [7:0]      ttl;
    logic [7:0]      proto;
    logic [31:0]     src;
    logic [31:0]     dst;
    logic [3:0]      ihl;
    logic            en_k;

    assign en_k = en && (sel == 2'(k));

    ros2_eth_tx_wide_adapter #(.DATA_BYTES(DB)) u_dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_enable            (en_k),
      .i_din_data          (din),
      .i_din_empty_n       (empty_n),
      .o_din_rd_en         (rd_v[k]),
      .o_tx_hdr_valid      (hv_v[k]),
      .i_tx_hdr_ready      (hdr_ready),
      .o_tx_ip_dscp        (dscp),
      .o_tx_ip_ecn         (ecn),
      .o_tx_ip_length      (length),
      .o_tx_ip_ttl         (ttl),
      .o_tx_ip_protocol    (proto),
      .o_tx_ip_source_ip   (src),
      .o_tx_ip_dest_ip     (dst),
      .o_tx_ip_ihl         (ihl),
      .o_tx_payload_tvalid (tv_v[k]),
      .i_tx_payload_tready (tready),
      .o_tx_payload_tdata  (td),
      .o_tx_payload_tkeep  (tk),
      .o_tx_payload_tstrb  (ts),
      .o_tx_payload_tlast  (tl_v[k]),
      .o_hdr_error         (er_v[k])
    );

    assign hf_v[k] = {dscp, ecn, length, ttl, proto, src, dst, ihl};
    assign td_v[k] = 64'(td);
    assign tk_v[k] = 8'(tk);
    assign ts_v[k] = 8'(ts);
  end

  logic         rd_en, hdr_valid, tvalid, tlast, hdr_error;
  logic [107:0] hdr_obs;
  logic [63:0]  tdata;
  logic [7:0]   tkeep, tstrb;

  always_comb begin
    rd_en     = rd_v[sel];
    hdr_valid = hv_v[sel];
    hdr_obs   = hf_v[sel];
    tvalid    = tv_v[sel];
    tdata     = td_v[sel];
    tkeep     = tk_v[sel];
    tstrb     = ts_v[sel];
    tlast     = tl_v[sel];
    hdr_error = er_v[sel];
  end

  logic [7:0]   fifo_q [$];
  logic [107:0] hdr_exp [$];
  word_t        word_exp [$];

  int     n_cmp = 0;
  int     n_bad = 0;
  int     err_exp = 0;
  int     err_seen = 0;
  bit     err_prev = 1'b0;
  bit     pop_seen = 1'b0;
  bit     hdr_stall = 1'b0;
  bit     word_stall = 1'b0;
  logic [107:0] hdr_held;
  word_t  word_held;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int cur_db();
    return (sel == 2'd0) ? 4 : ((sel == 2'd1) ? 1 : 8);
  endfunction

  task automatic drive();
    empty_n   = (fifo_q.size() != 0) && (!rnd || $urandom_range(0, 3) != 0);
    din       = empty_n ? fifo_q[0] : 8'($urandom);
    tready    = !rnd || $urandom_range(0, 2) != 0;
    hdr_ready = !rnd || $urandom_range(0, 2) != 0;
  endtask

  // Queue one packet's bytes and predict what must come out for it.
  task automatic send(input logic [3:0] ver, input logic [3:0] ihl, input logic [15:0] len,
                      input bit incr, input logic [7:0] base);
    logic [7:0]  hb [20];
    logic [5:0]  dscp;
    logic [1:0]  ecn;
    logic [7:0]  ttl, proto;
    logic [31:0] src, dst;
    word_t       w;
    int          n, lane;
    dscp  = 6'($urandom);
    ecn   = 2'($urandom);
    ttl   = 8'($urandom);
    proto = incr ? 8'h11 : 8'($urandom);
    src   = $urandom;
    dst   = $urandom;
    for (int i = 0; i < 20; i++) hb[i] = 8'($urandom);
    hb[0] = {ver, ihl};
    hb[1] = {dscp, ecn};
    hb[2] = len[15:8];
    hb[3] = len[7:0];
    hb[8] = ttl;
    hb[9] = proto;
    for (int i = 0; i < 4; i++) begin
      hb[12+i] = src[31-8*i -: 8];
      hb[16+i] = dst[31-8*i -: 8];
    end
    for (int i = 0; i < 20; i++) fifo_q.push_back(hb[i]);
    if (ver != 4'd4 || ihl < 4'd5 || int'(len) < 4 * int'(ihl)) begin
      err_exp++;
      return;
    end
    for (int i = 20; i < 4 * int'(ihl); i++) fifo_q.push_back(incr ? 8'hAA : 8'($urandom));
    hdr_exp.push_back({dscp, ecn, len, ttl, proto, src, dst, ihl});
    n    = int'(len) - 4 * int'(ihl);
    w    = '0;
    lane = 0;
    for (int i = 0; i < n; i++) begin
      w.data[8*lane +: 8] = incr ? 8'(base + 8'(i)) : 8'($urandom);
      fifo_q.push_back(w.data[8*lane +: 8]);
      lane++;
      if (lane == cur_db() || i == n - 1) begin
        w.keep = 8'((1 << lane) - 1);
        w.last = (i == n - 1);
        word_exp.push_back(w);
        w    = '0;
        lane = 0;
      end
    end
  endtask

  task automatic send_rand();
    int          k   = $urandom_range(0, 5);
    logic [3:0]  ver = 4'd4;
    logic [3:0]  ihl = 4'($urandom_range(5, 7));
    logic [15:0] len;
    len = 16'(4 * int'(ihl) + int'($urandom_range(0, 20)));
    if (k == 0) ver = 4'($urandom_range(5, 15));
    else if (k == 1) ihl = 4'($urandom_range(0, 4));
    else if (k == 2) len = 16'($urandom_range(0, 4 * int'(ihl) - 1));
    send(ver, ihl, len, 1'b0, 8'h00);
  endtask

  // One clock: observe at the falling edge, then update the FIFO model after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (rd_en) check("rd_en_without_data", 128'(empty_n), 128'd1);
    if (hdr_stall) check("hdr_hold", 128'({hdr_valid, hdr_obs}), 128'({1'b1, hdr_held}));
    if (word_stall) begin
      check("word_hold", 128'({tvalid, tdata, tkeep, tlast}), 128'({1'b1, word_held}));
    end
    if (en && hdr_valid && hdr_ready) begin
      check("hdr_expected", 128'(hdr_exp.size() != 0), 128'd1);
      if (hdr_exp.size() != 0) check("hdr_fields", 128'(hdr_obs), 128'(hdr_exp.pop_front()));
    end
    if (en && tvalid && tready) begin
      check("word_expected", 128'(word_exp.size() != 0), 128'd1);
      if (word_exp.size() != 0) begin
        check("tstrb_eq_tkeep", 128'(tstrb), 128'(word_exp[0].keep));
        check("word_data_keep_last", 128'({tdata, tkeep, tlast}), 128'(word_exp.pop_front()));
      end
    end
    if (hdr_error) begin
      err_seen++;
      check("hdr_error_pulse_width", 128'(err_prev), 128'd0);
    end
    err_prev   = hdr_error;
    hdr_stall  = en && hdr_valid && !hdr_ready;
    hdr_held   = hdr_obs;
    word_stall = en && tvalid && !tready;
    word_held  = {tdata, tkeep, tlast};
    pop_seen   = rd_en;
    @(posedge clk);
    #1;
    if (pop_seen && fifo_q.size() != 0) void'(fifo_q.pop_front());
    drive();
  endtask

  task automatic run_idle(input string tag, input int bound);
    int c = 0;
    while ((fifo_q.size() != 0 || hdr_exp.size() != 0 || word_exp.size() != 0) && c < bound) begin
      tick();
      c++;
    end
    check(tag, 128'(c < bound), 128'd1);
    repeat (4) tick();
  endtask

  initial begin
    int c;
    rst_n     = 1'b0;
    en        = 1'b1;
    sel       = 2'd0;
    rnd       = 1'b0;
    empty_n   = 1'b0;
    din       = 8'h00;
    tready    = 1'b1;
    hdr_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_hdr_valid", 128'(hdr_valid), 128'd0);
    check("rst_tvalid", 128'(tvalid), 128'd0);
    check("rst_tdata_keep_last", 128'({tdata, tkeep, tlast}), 128'd0);
    check("rst_hdr_fields", 128'(hdr_obs), 128'd0);
    check("rst_hdr_error", 128'(hdr_error), 128'd0);
    check("rst_rd_en", 128'(rd_en), 128'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive();

    // DATA_BYTES=4 directed packets, FIFO never empty, no backpressure.
    send(4'd4, 4'd5, 16'h001C, 1'b1, 8'h01);
    run_idle("drain_len_1c", 300);
    send(4'd4, 4'd5, 16'h001B, 1'b1, 8'h01);
    run_idle("drain_len_1b", 300);
    send(4'd4, 4'd6, 16'h001E, 1'b1, 8'h11);
    run_idle("drain_options", 300);
    send(4'd6, 4'd5, 16'h001C, 1'b1, 8'h01);
    send(4'd4, 4'd5, 16'h001C, 1'b1, 8'h21);
    run_idle("drain_bad_then_good", 300);
    send(4'd4, 4'd5, 16'h0014, 1'b1, 8'h00);
    run_idle("drain_no_payload", 300);

    // Random gaps and backpressure on the 1-byte and 8-byte instances.
    sel = 2'd1;
    rnd = 1'b1;
    repeat (12) send_rand();
    run_idle("drain_db1_random", 6000);
    sel = 2'd2;
    repeat (12) send_rand();
    run_idle("drain_db8_random", 6000);

    // Abort in the middle of an 8-byte-wide payload.
    send(4'd4, 4'd5, 16'd60, 1'b0, 8'h00);
    c = 0;
    while (word_exp.size() > 3 && c < 2000) begin
      tick();
      c++;
    end
    check("abort_reached_mid_payload", 128'(c < 2000), 128'd1);
    en = 1'b0;
    fifo_q.delete();
    hdr_exp.delete();
    word_exp.delete();
    drive();
    tick();
    @(negedge clk);
    check("abort_tvalid_cleared", 128'(tvalid), 128'd0);
    check("abort_hdr_valid_cleared", 128'(hdr_valid), 128'd0);
    tick();
    en = 1'b1;
    send(4'd4, 4'd6, 16'd45, 1'b0, 8'h00);
    run_idle("drain_after_abort", 2000);

    check("hdr_error_count", 128'(err_seen), 128'(err_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
